// File: rtl/dct8x8_row_pack.sv
// dct8x8_row_pack: converts pixels to signed lanes and packs 8 of them into one row
// word for the DCT transpose buffer. Define DCT8X8_ROW_PACK_LVL_SHIFT_EN for level shift.
// Revision: 1.0

`default_nettype none

module dct8x8_row_pack #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pix_vld_i,
    input  logic [DATA_WIDTH-1:0]     pix_data_i,
    input  logic                      pix_sof_i,
    output logic                      pix_rdy_i,
    output logic                      pack_vld_o,
    output logic [16*DATA_WIDTH-1:0]  pack_data_o,
    input  logic                      pack_rdy_o,
    output logic                      pack_row_flag_o,
    output logic                      pack_last_o,
    output logic [2:0]                pack_row_o
);

    localparam int LANE_W = 2 * DATA_WIDTH;

    logic [LANE_W-1:0]            w_lane;
    logic                         w_accept;

    logic [2:0]                   col_cnt_q,  col_cnt_d;
    logic [2:0]                   row_cnt_q,  row_cnt_d;
    logic                         blk_flag_q, blk_flag_d;
    logic [7:0][LANE_W-1:0]       stage_q,    stage_d;
    logic                         out_vld_q,  out_vld_d;
    logic [7:0][LANE_W-1:0]       out_data_q, out_data_d;
    logic                         out_flag_q, out_flag_d;
    logic                         out_last_q, out_last_d;
    logic [2:0]                   out_row_q,  out_row_d;

`ifdef DCT8X8_ROW_PACK_LVL_SHIFT_EN
    localparam logic [LANE_W-1:0] LVL_OFFSET = {{(LANE_W-1){1'b0}}, 1'b1} << (DATA_WIDTH - 1);
    // Modular subtraction of the mid-scale value yields the sign-extended result directly.
    assign w_lane = {{DATA_WIDTH{1'b0}}, pix_data_i} - LVL_OFFSET;
`else
    assign w_lane = {{DATA_WIDTH{1'b0}}, pix_data_i};
`endif

    // Stall only when a row would complete into an occupied, non-draining output register.
    assign pix_rdy_i = !((col_cnt_q == 3'd7) && out_vld_q && !pack_rdy_o);
    assign w_accept  = pix_vld_i && pix_rdy_i;

    always_comb begin
        col_cnt_d  = col_cnt_q;
        row_cnt_d  = row_cnt_q;
        blk_flag_d = blk_flag_q;
        stage_d    = stage_q;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_flag_d = out_flag_q;
        out_last_d = out_last_q;
        out_row_d  = out_row_q;

        if (out_vld_q && pack_rdy_o) begin
            out_vld_d = 1'b0;
        end

        if (w_accept) begin
            if (pix_sof_i) begin
                // Restart the block; the partial row is abandoned.
                stage_d[0] = w_lane;
                col_cnt_d  = 3'd1;
                row_cnt_d  = 3'd0;
                if (row_cnt_q != 3'd0) begin
                    blk_flag_d = !blk_flag_q;
                end
            end else begin
                stage_d[col_cnt_q] = w_lane;
                col_cnt_d          = col_cnt_q + 3'd1;
                if (col_cnt_q == 3'd7) begin
                    out_data_d    = stage_q;
                    out_data_d[7] = w_lane;
                    out_vld_d     = 1'b1;
                    out_row_d     = row_cnt_q;
                    out_last_d    = (row_cnt_q == 3'd7);
                    out_flag_d    = blk_flag_q;
                    row_cnt_d     = row_cnt_q + 3'd1;
                    if (row_cnt_q == 3'd7) begin
                        blk_flag_d = !blk_flag_q;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt_q  <= '0;
            row_cnt_q  <= '0;
            blk_flag_q <= 1'b0;
            stage_q    <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_flag_q <= 1'b0;
            out_last_q <= 1'b0;
            out_row_q  <= '0;
        end else begin
            col_cnt_q  <= col_cnt_d;
            row_cnt_q  <= row_cnt_d;
            blk_flag_q <= blk_flag_d;
            stage_q    <= stage_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_flag_q <= out_flag_d;
            out_last_q <= out_last_d;
            out_row_q  <= out_row_d;
        end
    end

    assign pack_vld_o      = out_vld_q;
    assign pack_data_o     = out_data_q;
    assign pack_row_flag_o = out_flag_q;
    assign pack_last_o     = out_last_q;
    assign pack_row_o      = out_row_q;

endmodule

`default_nettype wire

// File: tb/tb_dct8x8_row_pack.sv
// tb_dct8x8_row_pack: scoreboard bench for dct8x8_row_pack (DATA_WIDTH = 8).
// Revision: 1.0

`default_nettype none

module tb_dct8x8_row_pack;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pix_vld = 1'b0;
    logic [7:0]   pix_data = 8'h00;
    logic         pix_sof = 1'b0;
    logic         pix_rdy;
    logic         pack_vld;
    logic [127:0] pack_data;
    logic         pack_rdy = 1'b1;
    logic         pack_flag;
    logic         pack_last;
    logic [2:0]   pack_row;

    dct8x8_row_pack #(.DATA_WIDTH(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .pix_vld_i       (pix_vld),
        .pix_data_i      (pix_data),
        .pix_sof_i       (pix_sof),
        .pix_rdy_i       (pix_rdy),
        .pack_vld_o      (pack_vld),
        .pack_data_o     (pack_data),
        .pack_rdy_o      (pack_rdy),
        .pack_row_flag_o (pack_flag),
        .pack_last_o     (pack_last),
        .pack_row_o      (pack_row)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_words  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] conv(input logic [7:0] p);
`ifdef DCT8X8_ROW_PACK_LVL_SHIFT_EN
        return {8'h00, p} - 16'h0080;
`else
        return {8'h00, p};
`endif
    endfunction

    typedef struct {
        logic [127:0] data;
        int           row;
        bit           last;
        bit           flag;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [15:0] m_stage [8];
    int          m_col, m_row;
    bit          m_flag, m_vld, m_rdy;

    // Reference model: evaluated half a cycle ahead of each rising edge.
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) m_stage[k] = 16'h0000;
            m_col = 0; m_row = 0; m_flag = 0; m_vld = 0;
            sb.delete();
        end else begin
            check("vld", pack_vld, m_vld);
            m_rdy = !(m_col == 7 && m_vld && !pack_rdy);
            check("rdy", pix_rdy, m_rdy);
            if (m_vld) begin
                if (sb.size() == 0) begin
                    check("sb_empty", 1, 0);
                end else begin
                    check("data", pack_data, sb[0].data);
                    check("row",  pack_row,  sb[0].row);
                    check("last", pack_last, sb[0].last);
                    check("flag", pack_flag, sb[0].flag);
                    if (pack_rdy) begin
                        void'(sb.pop_front());
                        n_words++;
                        m_vld = 0;
                    end
                end
            end
            if (pix_vld && m_rdy) begin
                if (pix_sof) begin
                    m_stage[0] = conv(pix_data);
                    if (m_row != 0) m_flag = !m_flag;
                    m_col = 1;
                    m_row = 0;
                end else begin
                    m_stage[m_col] = conv(pix_data);
                    if (m_col == 7) begin
                        for (int k = 0; k < 8; k++) e.data[k*16 +: 16] = m_stage[k];
                        e.row  = m_row;
                        e.last = (m_row == 7);
                        e.flag = m_flag;
                        sb.push_back(e);
                        m_vld = 1;
                        if (m_row == 7) m_flag = !m_flag;
                        m_row = (m_row + 1) % 8;
                    end
                    m_col = (m_col + 1) % 8;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        pix_vld = 1'b0;
        pix_sof = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic sof);
        bit done = 0;
        pix_vld  = 1'b1;
        pix_data = d;
        pix_sof  = sof;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = pix_rdy;
            @(posedge clk); #1;
        end
        pix_vld = 1'b0;
        pix_sof = 1'b0;
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [127:0] w_exp;
    logic [7:0]   tbl [8];
    int           acc;
    int           w0;

    initial begin
        // Reset state
        #1;
        check("rst_vld",  pack_vld,  0);
        check("rst_data", pack_data, 0);
        check("rst_flag", pack_flag, 0);
        check("rst_last", pack_last, 0);
        check("rst_row",  pack_row,  0);
        idle(2);
        rst = 1'b0;
        idle(1);

        // Pixels 0..7 back to back
        for (int i = 0; i < 8; i++) send(8'(i), 0);
        for (int k = 0; k < 8; k++) w_exp[k*16 +: 16] = conv(8'(k));
        check("t1_vld",  pack_vld,  1);
        check("t1_data", pack_data, w_exp);
        check("t1_row",  pack_row,  0);
        check("t1_last", pack_last, 0);
        check("t1_flag", pack_flag, 0);
        idle(2);

        // Two full blocks, 128 then 255
        do_reset();
        w0 = n_words;
        for (int i = 0; i < 64; i++) send(8'd128, 0);
        for (int i = 0; i < 64; i++) send(8'd255, 0);
        for (int k = 0; k < 8; k++) w_exp[k*16 +: 16] = conv(8'd255);
        check("t2_data", pack_data, w_exp);
        check("t2_last", pack_last, 1);
        check("t2_flag", pack_flag, 1);
        check("t2_row",  pack_row,  7);
        idle(3);
        check("t2_words", n_words - w0, 16);

        // Output stalled from the start: 15 of 16 pixels accepted
        do_reset();
        pack_rdy = 1'b0;
        acc = 0;
        pix_vld  = 1'b1;
        pix_data = 8'd0;
        for (int c = 0; c < 24; c++) begin
            bit a;
            @(negedge clk);
            a = pix_rdy;
            @(posedge clk); #1;
            if (a && acc < 15) begin
                acc++;
                pix_data = 8'(acc);
            end
        end
        check("t3_accepted", acc, 15);
        check("t3_rdy_low",  pix_rdy, 0);
        check("t3_hold_row", pack_row, 0);
        for (int k = 0; k < 8; k++) w_exp[k*16 +: 16] = conv(8'(k));
        check("t3_hold_data", pack_data, w_exp);
        pack_rdy = 1'b1;
        @(posedge clk); #1;
        pix_vld = 1'b0;
        check("t3_reload_vld", pack_vld, 1);
        check("t3_reload_row", pack_row, 1);
        idle(3);

        // Start-of-block mid row 2
        do_reset();
        for (int i = 0; i < 19; i++) send(8'(i), 0);
        send(8'h10, 1);
        for (int i = 1; i < 8; i++) send(8'(16 + i), 0);
        check("t4_vld",   pack_vld, 1);
        check("t4_row",   pack_row, 0);
        check("t4_flag",  pack_flag, 1);
        check("t4_lane0", pack_data[15:0], conv(8'h10));
        idle(3);

        // Asynchronous reset with a stalled output mid row 5
        do_reset();
        for (int i = 0; i < 40; i++) send(8'(i), 0);
        pack_rdy = 1'b0;
        for (int i = 0; i < 3; i++) send(8'(i), 0);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("t5_vld",  pack_vld,  0);
        check("t5_data", pack_data, 0);
        check("t5_flag", pack_flag, 0);
        check("t5_last", pack_last, 0);
        check("t5_row",  pack_row,  0);
        check("t5_rdy",  pix_rdy,   1);
        @(posedge clk); #1;
        rst = 1'b0;
        pack_rdy = 1'b1;
        for (int i = 0; i < 8; i++) send(8'(i + 100), 0);
        check("t5_row_after",  pack_row,  0);
        check("t5_flag_after", pack_flag, 0);
        check("t5_vld_after",  pack_vld,  1);
        idle(2);

        // Extreme values
        do_reset();
        tbl[0] = 8'd0;   tbl[1] = 8'd255; tbl[2] = 8'd128; tbl[3] = 8'd1;
        tbl[4] = 8'd2;   tbl[5] = 8'd3;   tbl[6] = 8'd4;   tbl[7] = 8'd5;
        for (int i = 0; i < 8; i++) send(tbl[i], 0);
        for (int k = 0; k < 8; k++) check($sformatf("t6_lane%0d", k), pack_data[k*16 +: 16], conv(tbl[k]));
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
